// File: rtl/hs_mul_pkg.sv
// rtl/hs_mul_pkg.sv - shared state type, defaults and read-state helper for hs_mul_host
// HS_MUL_CHECK_EN adds the operand readback states CHK_A/CHK_B.
package hs_mul_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_SETTLE = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
`ifdef HS_MUL_CHECK_EN
        S_CHK_A,
        S_CHK_B,
`endif
        S_RD_LO,
        S_RD_HI,
        S_DONE
    } state_t;

    // States that hold a read-select setting and sample res_in on their final cycle.
    function automatic logic state_is_read(state_t s);
        logic r;
        r = 1'b0;
        case (s)
`ifdef HS_MUL_CHECK_EN
            S_CHK_A, S_CHK_B: r = 1'b1;
`endif
            S_RD_LO, S_RD_HI: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hs_mul_piso.sv
// rtl/hs_mul_piso.sv - dual-lane MSB-first parallel-in serial-out shifter
// Serial outputs are registered and return to 0 whenever the shifter is idle.
module hs_mul_piso #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sr_a;
    logic [WIDTH-1:0] sr_b;
    logic [CW-1:0]    cnt;

    // The MSB goes out on the load edge itself, so the register keeps only the remaining bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_a  <= '0;
            sr_b  <= '0;
            cnt   <= '0;
            ser_a <= 1'b0;
            ser_b <= 1'b0;
        end else if (load) begin
            ser_a <= data_a[WIDTH-1];
            ser_b <= data_b[WIDTH-1];
            sr_a  <= data_a << 1;
            sr_b  <= data_b << 1;
            cnt   <= '0;
        end else if (shift_en) begin
            ser_a <= sr_a[WIDTH-1];
            ser_b <= sr_b[WIDTH-1];
            sr_a  <= sr_a << 1;
            sr_b  <= sr_b << 1;
            cnt   <= cnt + 1'b1;
        end else begin
            ser_a <= 1'b0;
            ser_b <= 1'b0;
        end
    end

    assign done = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/hs_mul_host.sv
// rtl/hs_mul_host.sv - host driver for the serial-input multiplier: shift, latch, read back product
// HS_MUL_CHECK_EN adds operand readback (CHK_A/CHK_B) and the chk_err output.
module hs_mul_host
    import hs_mul_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               ser_a,
    output logic               ser_b,
    output logic               latch_gate,
    output logic               rd_op,
    output logic               rd_sel,
    output logic               mul_rst_n,
    input  logic [WIDTH-1:0]   res_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result
`ifdef HS_MUL_CHECK_EN
    ,
    output logic               chk_err
`endif
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    state_t        state;
    state_t        next_state;
    logic [SW-1:0] settle_cnt;
    logic          settle_last;
    logic          accept;
    logic          shift_done;
    logic          shift_en;
    logic          next_rd_op;
    logic          next_rd_sel;

    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_DONE);
    assign accept      = in_valid && in_ready;
    assign settle_last = (settle_cnt == SETTLE_LAST);
    assign shift_en    = (state == S_SHIFT) && !shift_done;

    hs_mul_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift_en (shift_en),
        .data_a   (in_a),
        .data_b   (in_b),
        .ser_a    (ser_a),
        .ser_b    (ser_b),
        .done     (shift_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        next_rd_op  = 1'b0;
        next_rd_sel = 1'b0;
        case (state)
            S_IDLE:  if (in_valid) next_state = S_SHIFT;
            S_SHIFT: if (shift_done) next_state = S_LATCH;
`ifdef HS_MUL_CHECK_EN
            S_LATCH: next_state = S_CHK_A;
            S_CHK_A: if (settle_last) next_state = S_CHK_B;
            S_CHK_B: if (settle_last) next_state = S_RD_LO;
`else
            S_LATCH: next_state = S_RD_LO;
`endif
            S_RD_LO: if (settle_last) next_state = S_RD_HI;
            S_RD_HI: if (settle_last) next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        case (next_state)
`ifdef HS_MUL_CHECK_EN
            S_CHK_A: next_rd_op = 1'b1;
            S_CHK_B: begin
                next_rd_op  = 1'b1;
                next_rd_sel = 1'b1;
            end
`endif
            S_RD_HI: next_rd_sel = 1'b1;
            default: ;
        endcase
    end

    // Each read setting restarts its own settle count on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                             settle_cnt <= '0;
        else if (next_state != state || !state_is_read(state)) settle_cnt <= '0;
        else                                                 settle_cnt <= settle_cnt + 1'b1;
    end

    // Pin controls are decoded from next_state so they change on the same edge as the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_gate <= 1'b0;
            rd_op      <= 1'b0;
            rd_sel     <= 1'b0;
            mul_rst_n  <= 1'b0;
        end else begin
            latch_gate <= (next_state == S_LATCH);
            rd_op      <= next_rd_op;
            rd_sel     <= next_rd_sel;
            mul_rst_n  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
        end else if (settle_last && state == S_RD_LO) begin
            out_result[WIDTH-1:0] <= res_in;
        end else if (settle_last && state == S_RD_HI) begin
            out_result[2*WIDTH-1:WIDTH] <= res_in;
        end
    end

`ifdef HS_MUL_CHECK_EN
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cap   <= '0;
            b_cap   <= '0;
            chk_err <= 1'b0;
        end else if (accept) begin
            a_cap   <= in_a;
            b_cap   <= in_b;
            chk_err <= 1'b0;
        end else if (settle_last && state == S_CHK_A && res_in != a_cap) begin
            chk_err <= 1'b1;
        end else if (settle_last && state == S_CHK_B && res_in != b_cap) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hs_mul_host.sv
// tb/tb_hs_mul_host.sv - self-checking bench for hs_mul_host with a behavioural serial multiplier
// Honours HS_MUL_CHECK_EN (extra latency, chk_err port, corrupted readback case).
`timescale 1ns/1ps
module tb_hs_mul_host;

    localparam int WIDTH  = 16;
    localparam int SETTLE = 2;
`ifdef HS_MUL_CHECK_EN
    localparam int LAT = WIDTH + 1 + 4 * SETTLE;
`else
    localparam int LAT = WIDTH + 1 + 2 * SETTLE;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic               ser_a, ser_b, latch_gate, rd_op, rd_sel, mul_rst_n;
    logic [WIDTH-1:0]   res_in;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [2*WIDTH-1:0] out_result;
`ifdef HS_MUL_CHECK_EN
    logic               chk_err;
`endif

    always #5 clk = ~clk;

    hs_mul_host #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .ser_a      (ser_a),
        .ser_b      (ser_b),
        .latch_gate (latch_gate),
        .rd_op      (rd_op),
        .rd_sel     (rd_sel),
        .mul_rst_n  (mul_rst_n),
        .res_in     (res_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef HS_MUL_CHECK_EN
        ,
        .chk_err    (chk_err)
`endif
    );

    // Behavioural multiplier: free-running shift registers, operand latch, muxed readback.
    logic [WIDTH-1:0]   sh_a = '0, sh_b = '0, la = '0, lb = '0;
    logic               corrupt = 1'b0;
    logic [2*WIDTH-1:0] prod;

    always @(posedge clk) begin
        if (!mul_rst_n) begin
            sh_a <= '0;
            sh_b <= '0;
            la   <= '0;
            lb   <= '0;
        end else begin
            sh_a <= {sh_a[WIDTH-2:0], ser_a};
            sh_b <= {sh_b[WIDTH-2:0], ser_b};
            if (latch_gate) begin
                la <= sh_a;
                lb <= sh_b;
            end
        end
    end

    assign prod = {{WIDTH{1'b0}}, la} * {{WIDTH{1'b0}}, lb};

    always_comb begin
        res_in = '0;
        if (rd_op) res_in = rd_sel ? (lb ^ {{(WIDTH-1){1'b0}}, corrupt}) : la;
        else       res_in = rd_sel ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] exp;
        int                 hold;
        logic               bad;
    } vec_t;

    vec_t vecs[$];

    task automatic run_txn(input vec_t v, input string tag);
        int               cyc;
        int               lcyc;
        int               lcnt;
        int               hold_bad;
        logic [WIDTH-1:0] sa, sb;
        logic [2*WIDTH-1:0] held;
        corrupt = v.bad;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check($sformatf("%s in_ready before accept", tag), 64'(in_ready), 64'd1);
        in_a = v.a; in_b = v.b; in_valid = 1'b1;
        out_ready = (v.hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~v.a; in_b = ~v.b;
        sa = '0; sb = '0; lcyc = -1; lcnt = 0; cyc = 0;
        while (!out_valid && cyc < 100) begin
            if (cyc < WIDTH) begin
                sa = {sa[WIDTH-2:0], ser_a};
                sb = {sb[WIDTH-2:0], ser_b};
            end
            if (latch_gate) begin
                lcnt++;
                if (lcyc < 0) lcyc = cyc;
            end
            @(posedge clk); #1; cyc++;
        end
        check($sformatf("%s latency", tag), 64'(cyc), 64'(LAT));
        check($sformatf("%s ser_a stream", tag), 64'(sa), 64'(v.a));
        check($sformatf("%s ser_b stream", tag), 64'(sb), 64'(v.b));
        check($sformatf("%s latch cycle", tag), 64'(lcyc), 64'(WIDTH));
        check($sformatf("%s latch width", tag), 64'(lcnt), 64'd1);
        check($sformatf("%s result", tag), 64'(out_result), 64'(v.exp));
`ifdef HS_MUL_CHECK_EN
        check($sformatf("%s chk_err", tag), 64'(chk_err), 64'(v.bad));
`endif
        held = out_result;
        hold_bad = 0;
        for (int k = 0; k < v.hold; k++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0 || ser_a !== 1'b0)
                hold_bad++;
        end
        in_valid = 1'b0;
        if (v.hold > 0) check($sformatf("%s hold stable", tag), 64'(hold_bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("%s out_valid falls", tag), 64'(out_valid), 64'd0);
        check($sformatf("%s in_ready rises", tag), 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check($sformatf("%s no spurious accept", tag), 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s ser_a", tag), 64'(ser_a), 64'd0);
        check($sformatf("%s ser_b", tag), 64'(ser_b), 64'd0);
        check($sformatf("%s latch_gate", tag), 64'(latch_gate), 64'd0);
        check($sformatf("%s rd_op/rd_sel", tag), 64'({rd_op, rd_sel}), 64'd0);
        check($sformatf("%s out_valid", tag), 64'(out_valid), 64'd0);
        check($sformatf("%s mul_rst_n", tag), 64'(mul_rst_n), 64'd0);
        check($sformatf("%s out_result", tag), 64'(out_result), 64'd0);
`ifdef HS_MUL_CHECK_EN
        check($sformatf("%s chk_err", tag), 64'(chk_err), 64'd0);
`endif
    endtask

    initial begin
        vec_t v;
        logic [WIDTH-1:0] ra, rb;

        vecs.push_back('{16'h1234, 16'h5678, 32'h06260060, 0,  1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0,  1'b0});
        vecs.push_back('{16'h0000, 16'hABCD, 32'h00000000, 0,  1'b0});
        vecs.push_back('{16'h00FF, 16'h0101, 32'h0000FFFF, 10, 1'b0});
`ifdef HS_MUL_CHECK_EN
        vecs.push_back('{16'h1234, 16'h5678, 32'h06260060, 0,  1'b1});
        vecs.push_back('{16'h0002, 16'h0003, 32'h00000006, 0,  1'b0});
`endif

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        check("post-reset mul_rst_n", 64'(mul_rst_n), 64'd1);

        for (int i = 0; i < vecs.size(); i++)
            run_txn(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            v.a = ra; v.b = rb;
            v.exp = 32'(ra) * 32'(rb);
            v.hold = int'($urandom_range(0, 3));
            v.bad = 1'b0;
            run_txn(v, $sformatf("rand%0d", i));
        end

        // Abort in SHIFT cycle 7 with a nonzero product still held from the last transaction.
        in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        check("abort in_ready (IDLE)", 64'(in_ready), 64'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("abort recover mul_rst_n", 64'(mul_rst_n), 64'd1);
        run_txn('{16'h0003, 16'h0005, 32'h0000000F, 0, 1'b0}, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
